// File: rtl/seq_sreg_pkg.sv
// Shared definitions for the serial shift-register transmit/receive blocks.
package seq_sreg_pkg;

  localparam int SREG_NBITS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

endpackage

// File: rtl/seq_sreg_piso_dpath.sv
// Loadable MSB-first left-shift register with a bits-remaining down-counter.
module seq_sreg_piso_dpath
  import seq_sreg_pkg::*;
#(
  parameter int NBITS = SREG_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [NBITS-1:0] pin,
  output logic             msb,
  output logic             cnt_is_one
);

  localparam int CW = $clog2(NBITS + 1);

  logic [NBITS-1:0] sreg;
  logic [CW-1:0]    cnt;

  // load wins over clear so a back-to-back word is never dropped at the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= pin;
      cnt  <= CW'(NBITS);
    end else if (clear) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= {sreg[NBITS-2:0], 1'b0};
      cnt  <= cnt - CW'(1);
    end
  end

  assign msb        = sreg[NBITS-1];
  assign cnt_is_one = (cnt == CW'(1));

endmodule

// File: rtl/seq_sreg_piso_tx.sv
// Parallel-in serial-out transmitter: val/rdy word intake, MSB-first serial output with stall.
module seq_sreg_piso_tx
  import seq_sreg_pkg::*;
#(
  parameter int NBITS = SREG_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] pin,
  input  logic             stall,
  output logic             sout,
  output logic             sout_en,
  output logic             busy
);

  piso_state_t state, state_next;
  logic        msb;
  logic        cnt_is_one;
  logic        last_bit;
  logic        handshake;
  logic        load;
  logic        shift;
  logic        clear;

  // last_bit: the final bit of the frame is actually emitted this cycle
  assign last_bit  = (state == SHIFT) && !stall && cnt_is_one;
  assign in_rdy    = !reset && ((state == IDLE) || last_bit);
  assign handshake = in_val && in_rdy;
  assign load      = handshake;
  assign shift     = (state == SHIFT) && !stall && !cnt_is_one;
  assign clear     = last_bit && !in_val;

  seq_sreg_piso_dpath #(
    .NBITS(NBITS)
  ) u_dpath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .shift      (shift),
    .clear      (clear),
    .pin        (pin),
    .msb        (msb),
    .cnt_is_one (cnt_is_one)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = SHIFT;
      SHIFT:   if (last_bit && !in_val) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sout    = 1'b0;
    sout_en = 1'b0;
    busy    = 1'b0;
    if (state == SHIFT) begin
      sout    = msb;
      sout_en = !stall;
      busy    = 1'b1;
    end
  end

endmodule
